// File: rtl/tetris_pkg.sv
// Shared encodings for the 4x8 Tetris game sequencer: phase codes, FSM states,
// spawn footprints, board edge masks and the full-row counter.
package tetris_pkg;

    localparam logic [2:0] PH_GEN  = 3'd0;
    localparam logic [2:0] PH_MOVE = 3'd1;
    localparam logic [2:0] PH_LOCK = 3'd2;
    localparam logic [2:0] PH_OVER = 3'd4;
    localparam logic [2:0] PH_IDLE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_OVER
    } state_t;

    // Index = piece code; bit = row*4+col.
    localparam logic [3:0][31:0] SPAWN_MASK = {
        32'h0000_0062,
        32'h0000_0066,
        32'h0000_0006,
        32'h0000_0002
    };

    localparam logic [31:0] COL0 = 32'h1111_1111;
    localparam logic [31:0] COL3 = 32'h8888_8888;
    localparam logic [31:0] ROW7 = 32'hF000_0000;

    function automatic logic [2:0] phase_of(state_t s);
        case (s)
            S_SPAWN: return PH_GEN;
            S_FALL:  return PH_MOVE;
            S_LOCK:  return PH_LOCK;
            S_OVER:  return PH_OVER;
            default: return PH_IDLE;
        endcase
    endfunction

    // Completed rows on the board, capped at two lines per lock.
    function automatic logic [1:0] full_rows(logic [31:0] b);
        logic [3:0] n;
        n = 4'd0;
        for (int r = 0; r < 8; r++) begin
            if (b[r*4 +: 4] == 4'hF) n = n + 4'd1;
        end
        return (n > 4'd2) ? 2'd2 : n[1:0];
    endfunction

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Board-datapath control bus between the game sequencer and its environment.
interface tetris_game_ctrl_if;
    logic        start;
    logic        tick;
    logic        btn_left;
    logic        btn_right;
    logic [31:0] board_in;
    logic        dp_error;
    logic [2:0]  phase;
    logic [1:0]  curr_piece;
    logic [31:0] board_drive;
    logic        drive_en;
    logic [7:0]  score;
    logic        game_over;

    modport master (
        output start, tick, btn_left, btn_right, board_in, dp_error,
        input  phase, curr_piece, board_drive, drive_en, score, game_over
    );

    modport slave (
        input  start, tick, btn_left, btn_right, board_in, dp_error,
        output phase, curr_piece, board_drive, drive_en, score, game_over
    );
endinterface

// File: rtl/tetris_piece_lfsr.sv
// 4-bit Fibonacci LFSR (x^4+x^3+1) supplying the next piece code; free-running.
module tetris_piece_lfsr (
    input  logic       clka,
    input  logic       restart,
    input  logic [3:0] seed,
    output logic [3:0] lfsr
);

    always_ff @(posedge clka) begin
        if (restart) lfsr <= seed;
        else         lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Game sequencer: spawns pieces, issues move/drop board writes, detects landing,
// scores cleared lines and flags game over.
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int         DP_LAT    = 2,
    parameter logic [3:0] LFSR_SEED = 4'b1001
) (
    input  logic                 clka,
    input  logic                 restart,
    tetris_game_ctrl_if.slave    bus
);

    localparam logic [7:0] LAT = 8'(DP_LAT);

    state_t      state, state_nx;
    logic [31:0] mask, mask_nx;
    logic [31:0] board_drive, drive_nx;
    logic        drive_en, den_nx;
    logic [7:0]  wait_cnt, wait_nx;
    logic [7:0]  score, score_nx;
    logic [1:0]  curr_piece, piece_nx;
    logic [1:0]  next_piece;
    logic [1:0]  lfsr_hi_unused;

    tetris_piece_lfsr u_lfsr (
        .clka    (clka),
        .restart (restart),
        .seed    (LFSR_SEED),
        .lfsr    ({lfsr_hi_unused, next_piece})
    );

    logic [31:0] rest, dn_mask, lt_mask, rt_mask;
    logic        dn_blk, lt_blk, rt_blk, ready;
    logic [8:0]  score_sum;

    assign rest    = bus.board_in & ~mask;
    assign dn_mask = mask << 4;
    assign lt_mask = mask >> 1;
    assign rt_mask = mask << 1;
    assign dn_blk  = (|(mask & ROW7)) || (|(dn_mask & rest));
    assign lt_blk  = (|(mask & COL0)) || (|(lt_mask & rest));
    assign rt_blk  = (|(mask & COL3)) || (|(rt_mask & rest));
    // The extra drive_en term keeps strobes apart even when DP_LAT is 0.
    assign ready     = (wait_cnt == 8'd0) && !drive_en;
    assign score_sum = {1'b0, score} + 9'(full_rows(bus.board_in));

    always_ff @(posedge clka) begin
        if (restart) begin
            state       <= S_IDLE;
            mask        <= '0;
            board_drive <= '0;
            drive_en    <= 1'b0;
            wait_cnt    <= '0;
            score       <= '0;
            curr_piece  <= '0;
        end else begin
            state       <= state_nx;
            mask        <= mask_nx;
            board_drive <= drive_nx;
            drive_en    <= den_nx;
            wait_cnt    <= wait_nx;
            score       <= score_nx;
            curr_piece  <= piece_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        drive_nx = board_drive;
        den_nx   = 1'b0;
        wait_nx  = (wait_cnt != 8'd0) ? wait_cnt - 8'd1 : 8'd0;
        score_nx = score;
        piece_nx = curr_piece;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_SPAWN;
                    piece_nx = next_piece;
                    wait_nx  = LAT;
                end
            end
            S_SPAWN: begin
                if (wait_cnt == 8'd0) begin
                    if (bus.dp_error) begin
                        state_nx = S_OVER;
                    end else begin
                        mask_nx  = SPAWN_MASK[curr_piece];
                        state_nx = S_FALL;
                    end
                end
            end
            S_FALL: begin
                if (ready) begin
                    if (bus.tick) begin
                        if (dn_blk) begin
                            state_nx = S_LOCK;
                            score_nx = score_sum[8] ? 8'hFF : score_sum[7:0];
                            wait_nx  = LAT;
                        end else begin
                            drive_nx = rest | dn_mask;
                            den_nx   = 1'b1;
                            mask_nx  = dn_mask;
                            wait_nx  = LAT;
                        end
                    end else if (bus.btn_left && !bus.btn_right && !lt_blk) begin
                        drive_nx = rest | lt_mask;
                        den_nx   = 1'b1;
                        mask_nx  = lt_mask;
                        wait_nx  = LAT;
                    end else if (bus.btn_right && !bus.btn_left && !rt_blk) begin
                        drive_nx = rest | rt_mask;
                        den_nx   = 1'b1;
                        mask_nx  = rt_mask;
                        wait_nx  = LAT;
                    end
                end
            end
            S_LOCK: begin
                if (wait_cnt == 8'd0) begin
                    state_nx = S_SPAWN;
                    piece_nx = next_piece;
                    wait_nx  = LAT;
                end
            end
            default: ;
        endcase
    end

    assign bus.phase       = phase_of(state);
    assign bus.game_over   = (state == S_OVER);
    assign bus.curr_piece  = curr_piece;
    assign bus.board_drive = board_drive;
    assign bus.drive_en    = drive_en;
    assign bus.score       = score;

endmodule
